ha_serial_arb: RTL and testbench

- Bit-serial adder controller that time-shares one full-adder slice between two requesters.
- The slice is built from two `half` instances plus an OR for carry-out.
- Each accepted request adds two W-bit operands LSB-first, one bit per clock, and returns sum and carry-out with a done pulse.
- Round-robin arbitration picks between requesters; this is the sequencing and arbitration layer above the half-adder datapath.

---
 rtl/ha_serial_arb.sv | 112 +++++++++++
 tb/tb_ha_serial_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_arb.sv
// Bit-serial adder shared by two requesters: one full-adder slice made of two
// half adders, stepped LSB-first under round-robin arbitration.
module half (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module ha_serial_arb #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         busy,
  output logic         owner,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  sa, sb, sum_sh, sum_nxt;
  logic [CW-1:0] cnt;
  logic          carry, last;
  logic          s1, c1, s2, c2, cy, pick1, last_bit;

  half ha1 (.a(sa[0]), .b(sb[0]), .s(s1), .c(c1));
  half ha2 (.a(s1),    .b(carry), .s(s2), .c(c2));

  assign cy       = c1 | c2;
  // New sum bit enters at the MSB; after W steps bit 0 sits at the LSB.
  assign sum_nxt  = W'({s2, sum_sh} >> 1);
  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign pick1    = req1 & (~req0 | ~last);
  assign last_bit = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      last   <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      busy   <= 1'b0;
      owner  <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            sa     <= pick1 ? a1 : a0;
            sb     <= pick1 ? b1 : b0;
            sum_sh <= '0;
            owner  <= pick1;
            last   <= pick1;
            ack0   <= ~pick1;
            ack1   <= pick1;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sum_sh <= sum_nxt;
          carry  <= cy;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum   <= sum_nxt;
            cout  <= cy;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ha_serial_arb.sv
// Bench for ha_serial_arb: directed cases plus randomized transactions checked
// against an arithmetic/round-robin model (W=8 and W=1 instances).
module tb_ha_serial_arb;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, busy, owner, done, cout;
  logic [W-1:0] sum;

  logic req0_s = 1'b0, req1_s = 1'b0;
  logic a0_s = 1'b0, b0_s = 1'b0, a1_s = 1'b0, b1_s = 1'b0;
  logic ack0_s, ack1_s, busy_s, owner_s, done_s, sum_s, cout_s;

  int  n_chk = 0, n_pass = 0;
  bit  last_srv = 1'b1;

  always #5 clk = ~clk;

  ha_serial_arb #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .owner(owner),
    .done(done), .sum(sum), .cout(cout)
  );

  ha_serial_arb #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_s), .a0(a0_s), .b0(b0_s),
    .req1(req1_s), .a1(a1_s), .b1(b1_s),
    .ack0(ack0_s), .ack1(ack1_s), .busy(busy_s), .owner(owner_s),
    .done(done_s), .sum(sum_s), .cout(cout_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Wait (bounded) for an ack pulse; n = negedges elapsed.
  task automatic wait_ack(output bit idx, output int n);
    bit seen = 1'b0;
    n = 0;
    idx = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (ack0 | ack1) seen = 1'b1;
    end
    chk("ack_seen", seen, 1'b1);
    chk("ack_onehot", ack0 & ack1, 1'b0);
    idx = ack1;
  endtask

  // Called on the ack cycle: follows the operation to its done pulse and
  // the following idle cycle.
  task automatic finish_op(input bit exp_own, input logic [W:0] exp_res);
    chk("busy_ack", busy, 1'b1);
    chk("owner", owner, exp_own);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      chk("run_done_low", done, 1'b0);
      chk("run_ack_low", ack0 | ack1, 1'b0);
      chk("run_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk("done", done, 1'b1);
    chk("busy_done", busy, 1'b1);
    chk("sum", sum, exp_res[W-1:0]);
    chk("cout", cout, exp_res[W]);
    chk("owner_done", owner, exp_own);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("sum_held", sum, exp_res[W-1:0]);
  endtask

  // One or two requests raised together from idle; each requester drops req
  // after its ack and scrambles its operands to prove grant-edge capture.
  task automatic do_pair(input bit r0, input bit r1,
                         input logic [W-1:0] va0, input logic [W-1:0] vb0,
                         input logic [W-1:0] va1, input logic [W-1:0] vb1);
    bit   exp_g, idx;
    int   n;
    logic [W:0] res;
    req0 = r0; a0 = va0; b0 = vb0;
    req1 = r1; a1 = va1; b1 = vb1;
    exp_g = (r0 && r1) ? ~last_srv : r1;
    for (int k = 0; k < ((r0 && r1) ? 2 : 1); k++) begin
      wait_ack(idx, n);
      chk("ack_latency", n, 1);
      chk("grant", idx, exp_g);
      last_srv = exp_g;
      res = exp_g ? ({1'b0, va1} + {1'b0, vb1}) : ({1'b0, va0} + {1'b0, vb0});
      if (exp_g) begin req1 = 1'b0; a1 = W'($urandom); b1 = W'($urandom); end
      else       begin req0 = 1'b0; a0 = W'($urandom); b0 = W'($urandom); end
      finish_op(exp_g, res);
      exp_g = ~exp_g;
    end
  endtask

  initial begin
    bit idx;
    int n, dones;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {ack0, ack1, done, owner, cout}, 5'd0);
    chk("rst_sum", sum, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Both held from reset: grants alternate 0,1,0,1, W+2 cycles apart.
    req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h80;
    for (int g = 0; g < 4; g++) begin
      wait_ack(idx, n);
      chk("tie_gap", n, 1);
      chk("tie_grant", idx, g[0]);
      if (g == 3) begin req0 = 1'b0; req1 = 1'b0; end
      finish_op(g[0], g[0] ? 9'h100 : 9'h030);
    end
    last_srv = 1'b1;

    do_pair(1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00);
    do_pair(1'b0, 1'b1, 8'h00, 8'h00, 8'h5A, 8'h3C);

    // Abort mid-run with reset.
    req0 = 1'b1; a0 = 8'hAA; b0 = 8'h55;
    wait_ack(idx, n);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_outs", {ack0, ack1, done, owner, cout}, 5'd0);
    chk("abort_sum", sum, '0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    rst_n = 1'b1;
    last_srv = 1'b1;
    @(negedge clk);
    do_pair(1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00);
    do_pair(1'b1, 1'b1, 8'hC3, 8'h7F, 8'hE0, 8'h31);

    for (int t = 0; t < 30; t++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      do_pair(r0, r1, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    // W=1 instance.
    req0_s = 1'b1; a0_s = 1'b1; b0_s = 1'b1;
    @(negedge clk);
    chk("w1_ack", {ack1_s, ack0_s}, 2'b01);
    chk("w1_busy", busy_s, 1'b1);
    chk("w1_done_early", done_s, 1'b0);
    req0_s = 1'b0; a0_s = 1'b0; b0_s = 1'b0;
    @(negedge clk);
    chk("w1_done", done_s, 1'b1);
    chk("w1_res", {cout_s, sum_s}, 2'b10);
    @(negedge clk);
    chk("w1_idle", {done_s, busy_s}, 2'b00);
    req0_s = 1'b1; a0_s = 1'b1; b0_s = 1'b0;
    @(negedge clk);
    chk("w1_ack2", ack0_s, 1'b1);
    req0_s = 1'b0;
    @(negedge clk);
    chk("w1_done2", done_s, 1'b1);
    chk("w1_res2", {cout_s, sum_s}, 2'b01);
    chk("w1_owner", owner_s, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
